axi4_slave_ram: RTL and testbench

AXI4_SLAVE_RAM -- requirements
Module: axi4_slave_ram

---
 rtl/axi4_slave_ram.sv | 197 +++++++++++++++++++
 tb/tb_axi4_slave_ram.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_slave_ram.sv
// axi4_slave_ram: AXI4 slave backed by a word-addressed RAM, one burst in flight per direction
module axi4_slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [63:0]             AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [63:0]             ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    localparam int IW  = $clog2(MEM_DEPTH);
    localparam int AB  = LSB + IW;
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] WRAP = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] step, mask;
        step = 64'd1 << size;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        return burst == INCR ? a + step : burst == WRAP ? (a & ~mask) | ((a + step) & mask) : a;
    endfunction

    function automatic logic oor(input logic [63:0] a);
        return a[63:AB] != '0;
    endfunction

    // An unsupported WRAP shape degrades to a full-width INCR burst that answers SLVERR
    function automatic logic bad_wrap(input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
        return burst == WRAP && (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) || int'(size) > LSB);
    endfunction

    wstate_t               w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [63:0]           aw_addr_q;
    logic [7:0]            aw_len_q, w_beat_q;
    logic [2:0]            aw_size_q;
    logic [1:0]            aw_burst_q;
    logic                  w_err_q, w_last, w_hs, aw_bad;

    assign w_last = w_beat_q == aw_len_q;
    assign w_hs   = WVALID && WREADY;
    assign aw_bad = bad_wrap(AWBURST, AWLEN, AWSIZE);
    assign BID    = BVALID ? aw_id_q : '0;
    assign BRESP  = {BVALID && w_err_q, 1'b0};

    // Write FSM next state and handshake outputs
    always_comb begin
        w_state_d = w_state_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) w_state_d = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_last) w_state_d = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write burst context: captured on AW, advanced per W beat
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_beat_q   <= '0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (AWVALID && AWREADY) begin
                aw_id_q    <= AWID;
                aw_addr_q  <= AWADDR;
                aw_len_q   <= AWLEN;
                aw_size_q  <= aw_bad ? 3'(LSB) : AWSIZE;
                aw_burst_q <= aw_bad ? INCR : AWBURST;
                w_beat_q   <= '0;
                w_err_q    <= aw_bad;
            end else if (w_hs) begin
                aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                w_beat_q  <= w_beat_q + 8'd1;
                if (oor(aw_addr_q) || WLAST != w_last) w_err_q <= 1'b1;
            end
        end
    end

    // Byte-enabled RAM write; contents survive reset
    always_ff @(posedge ACLK) begin
        if (w_hs && !oor(aw_addr_q))
            for (int b = 0; b < DATA_WIDTH / 8; b++)
                if (WSTRB[b]) mem[aw_addr_q[LSB +: IW]][8*b +: 8] <= WDATA[8*b +: 8];
    end

    rstate_t               r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [63:0]           ar_addr_q, rd_sel;
    logic [7:0]            ar_len_q, r_beat_q;
    logic [2:0]            ar_size_q;
    logic [1:0]            ar_burst_q;
    logic                  r_err_q, r_last, ar_bad;
    logic [DATA_WIDTH-1:0] rdata_q, rd_word;

    assign r_last  = r_beat_q == ar_len_q;
    assign ar_bad  = bad_wrap(ARBURST, ARLEN, ARSIZE);
    assign rd_sel  = ARREADY ? ARADDR : next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
    assign rd_word = oor(rd_sel) ? '0 : mem[rd_sel[LSB +: IW]];
    assign RID     = RVALID ? ar_id_q : '0;
    assign RDATA   = RVALID ? rdata_q : '0;
    assign RRESP   = {RVALID && (r_err_q || oor(ar_addr_q)), 1'b0};
    assign RLAST   = RVALID && r_last;

    // Read FSM next state and handshake outputs
    always_comb begin
        r_state_d = r_state_q;
        ARREADY   = r_state_q == R_IDLE;
        RVALID    = r_state_q == R_DATA;
        if (ARREADY && ARVALID) r_state_d = R_DATA;
        if (RVALID && RREADY && r_last) r_state_d = R_IDLE;
    end

    // Read burst context; the beat word is registered so it holds through backpressure
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_beat_q   <= '0;
            r_err_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ARVALID && ARREADY) begin
                ar_id_q    <= ARID;
                ar_addr_q  <= ARADDR;
                ar_len_q   <= ARLEN;
                ar_size_q  <= ar_bad ? 3'(LSB) : ARSIZE;
                ar_burst_q <= ar_bad ? INCR : ARBURST;
                r_beat_q   <= '0;
                r_err_q    <= ar_bad;
                rdata_q    <= rd_word;
            end else if (RVALID && RREADY) begin
                ar_addr_q <= rd_sel;
                r_beat_q  <= r_beat_q + 8'd1;
                rdata_q   <= rd_word;
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_ram.sv
// tb_axi4_slave_ram: randomized scoreboard bench for axi4_slave_ram against a byte-array model
module tb_axi4_slave_ram;
    localparam int DW    = 32;
    localparam int IDW   = 4;
    localparam int BYTES = 1024;

    logic           ACLK = 1'b0, ARESET = 1'b1;
    logic [IDW-1:0] AWID = '0, ARID = '0, BID, RID;
    logic [63:0]    AWADDR = '0, ARADDR = '0;
    logic [7:0]     AWLEN = '0, ARLEN = '0;
    logic [2:0]     AWSIZE = '0, ARSIZE = '0;
    logic [1:0]     AWBURST = '0, ARBURST = '0, BRESP, RRESP;
    logic           AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [DW-1:0]  WDATA = '0, RDATA;
    logic [3:0]     WSTRB = '0;
    logic           BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0;

    axi4_slave_ram #(.DATA_WIDTH(DW), .ID_WIDTH(IDW), .MEM_DEPTH(256)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } rexp_t;
    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } bexp_t;

    int          checks = 0, errors = 0;
    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [7:0]  ref_mem [BYTES];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] adv(input logic [63:0] a, input int len, input int size, input int burst);
        logic [63:0] step, blk, base;
        step = 64'd1 << size;
        blk  = 64'(len + 1) * step;
        base = a - (a % blk);
        if (burst == 0) return a;
        if (burst == 1) return a + step;
        return base + ((a - base + step) % blk);
    endfunction

    function automatic bit norm(inout int len, inout int size, inout int burst);
        if (burst == 2 && (!(len == 1 || len == 3 || len == 7 || len == 15) || size > 2)) begin
            burst = 1;
            size  = 2;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic sig(input int ch);
        return ch == 0 ? AWREADY : ch == 1 ? WREADY : ch == 2 ? BVALID : ARREADY;
    endfunction

    task automatic await(input int ch, input string name);
        int n = 0;
        forever begin
            @(negedge ACLK);
            if (sig(ch)) break;
            if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL timeout_%s actual=0 required=1", name);
                break;
            end
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input int size, input int burst,
                            input logic [IDW-1:0] id, input logic [31:0] d0, input logic [3:0] strb,
                            input bit rnd, input int bad_last);
        logic [31:0] dv [256];
        logic [3:0]  sv [256];
        logic        lv [256];
        logic [63:0] a = addr;
        int ml = len, ms = size, mb = burst;
        bit err = norm(ml, ms, mb);
        for (int i = 0; i <= len; i++) begin
            dv[i] = rnd ? $urandom : d0 + 32'(i);
            sv[i] = strb == 4'h0 ? 4'($urandom_range(0, 15)) : strb;
            lv[i] = (i == len) ^ (i == bad_last);
            if (i == bad_last) err = 1'b1;
            if (a >= BYTES) err = 1'b1;
            else for (int b = 0; b < 4; b++) if (sv[i][b]) ref_mem[int'(a / 4) * 4 + b] = dv[i][8*b +: 8];
            a = adv(a, ml, ms, mb);
        end
        bq.push_back('{id, err ? 2'b10 : 2'b00});
        @(posedge ACLK); #1;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
        await(0, "aw");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                WVALID = 1'b0;
                @(posedge ACLK); #1;
            end
            WVALID = 1'b1; WDATA = dv[i]; WSTRB = sv[i]; WLAST = lv[i];
            await(1, "w");
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge ACLK);
        #1 BREADY = 1'b1;
        await(2, "b");
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input int size, input int burst,
                           input logic [IDW-1:0] id, input int stall_at, input int abort_at);
        logic [63:0] a = addr;
        int ml = len, ms = size, mb = burst, n = 0, done;
        bit bad = norm(ml, ms, mb), stalled = 1'b0;
        for (int i = 0; i <= len; i++) begin
            rexp_t e;
            e.id   = id;
            e.last = i == len;
            e.data = '0;
            e.resp = 2'b10;
            if (a < BYTES) begin
                for (int b = 0; b < 4; b++) e.data[8*b +: 8] = ref_mem[int'(a / 4) * 4 + b];
                e.resp = bad ? 2'b10 : 2'b00;
            end
            rq.push_back(e);
            a = adv(a, ml, ms, mb);
        end
        @(posedge ACLK); #1;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
        await(3, "ar");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        while (rq.size() > 0) begin
            done = len + 1 - rq.size();
            if (done == abort_at) begin
                ARESET = 1'b1;
                #1;
                chk("rst_rvalid", 64'(RVALID), 64'd0);
                chk("rst_arready", 64'(ARREADY), 64'd1);
                chk("rst_awready", 64'(AWREADY), 64'd1);
                chk("rst_rdata", 64'(RDATA), 64'd0);
                chk("rst_rlast", 64'(RLAST), 64'd0);
                rq.delete();
                RREADY = 1'b0;
                @(posedge ACLK); #1;
                ARESET = 1'b0;
                break;
            end
            if (done == stall_at && !stalled) begin
                stalled = 1'b1;
                RREADY  = 1'b0;
                repeat (5) @(posedge ACLK);
                #1;
            end
            RREADY = $urandom_range(0, 3) != 0;
            @(posedge ACLK); #1;
            if (++n > 2000) begin
                checks++;
                errors++;
                $display("FAIL timeout_r actual=%0d_beats_left required=0", rq.size());
                rq.delete();
            end
        end
        RREADY = 1'b0;
    endtask

    bexp_t          be;
    rexp_t          re;
    logic           stall_prev = 1'b0, p_last;
    logic [DW-1:0]  p_data;
    logic [1:0]     p_resp;
    logic [IDW-1:0] p_id;

    // Monitor: pops the scoreboard on every B/R handshake and checks R stability under backpressure
    always @(negedge ACLK) begin
        if (ARESET) stall_prev <= 1'b0;
        else begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected actual=bresp_%0h required=none", BRESP);
                end else begin
                    be = bq.pop_front();
                    chk("bid", 64'(BID), 64'(be.id));
                    chk("bresp", 64'(BRESP), 64'(be.resp));
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected actual=rdata_%0h required=none", RDATA);
                end else begin
                    re = rq.pop_front();
                    chk("rid", 64'(RID), 64'(re.id));
                    chk("rdata", 64'(RDATA), 64'(re.data));
                    chk("rresp", 64'(RRESP), 64'(re.resp));
                    chk("rlast", 64'(RLAST), 64'(re.last));
                end
            end
            if (stall_prev) begin
                chk("stall_rvalid", 64'(RVALID), 64'd1);
                chk("stall_rdata", 64'(RDATA), 64'(p_data));
                chk("stall_rlast", 64'(RLAST), 64'(p_last));
                chk("stall_rresp", 64'(RRESP), 64'(p_resp));
                chk("stall_rid", 64'(RID), 64'(p_id));
            end
            stall_prev <= RVALID && !RREADY;
            p_data     <= RDATA;
            p_last     <= RLAST;
            p_resp     <= RRESP;
            p_id       <= RID;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_awready", 64'(AWREADY), 64'd1);
        chk("reset_arready", 64'(ARREADY), 64'd1);
        chk("reset_wready", 64'(WREADY), 64'd0);
        chk("reset_bvalid", 64'(BVALID), 64'd0);
        chk("reset_rvalid", 64'(RVALID), 64'd0);
        ARESET = 1'b0;
        do_write(64'h0, 255, 2, 1, 4'h1, 32'h0, 4'hF, 1'b1, -1);
        do_write(64'h10, 3, 2, 1, 4'h3, 32'hA0, 4'hF, 1'b0, -1);
        do_read(64'h10, 3, 2, 1, 4'h5, -1, -1);
        do_read(64'h18, 3, 2, 2, 4'h6, -1, -1);
        do_write(64'h40, 0, 2, 1, 4'h7, 32'hFFFF_FFFF, 4'hF, 1'b0, -1);
        do_write(64'h40, 0, 2, 1, 4'h8, 32'h1234_5678, 4'h3, 1'b0, -1);
        do_read(64'h40, 0, 2, 1, 4'h9, -1, -1);
        do_write(64'h400, 1, 2, 1, 4'hA, 32'hDEAD_0000, 4'hF, 1'b0, -1);
        do_read(64'h400, 1, 2, 1, 4'hB, -1, -1);
        do_write(64'h3F8, 3, 2, 1, 4'hC, 32'hBEEF_0000, 4'hF, 1'b0, -1);
        do_read(64'h3F8, 3, 2, 1, 4'hD, -1, -1);
        do_write(64'h80, 3, 2, 1, 4'h2, 32'h5000, 4'hF, 1'b0, 1);
        do_write(64'h90, 1, 2, 1, 4'h4, 32'h6000, 4'hF, 1'b0, 1);
        do_read(64'h80, 5, 2, 1, 4'hE, -1, -1);
        do_write(64'h20, 2, 2, 2, 4'h1, 32'h7000, 4'hF, 1'b0, -1);
        do_read(64'h20, 2, 2, 2, 4'h2, -1, -1);
        do_read(64'h20, 3, 3, 2, 4'h3, -1, -1);
        do_write(64'h60, 3, 2, 0, 4'h4, 32'h8000, 4'h0, 1'b0, -1);
        do_read(64'h60, 3, 2, 0, 4'h5, -1, -1);
        for (int t = 0; t < 40; t++) begin
            logic [63:0] a = $urandom_range(0, 3) == 0 ? 64'(32'h3E0 + $urandom_range(0, 63))
                                                       : 64'($urandom_range(0, BYTES - 1));
            int l = $urandom_range(0, 15), s = $urandom_range(0, 2), b = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) do_write(a, l, s, b, 4'($urandom), 32'h0, 4'h0, 1'b1, -1);
            else do_read(a, l, s, b, 4'($urandom), -1, -1);
        end
        do_read(64'h100, 7, 2, 1, 4'h6, 3, -1);
        do_read(64'h100, 7, 2, 1, 4'h7, -1, 3);
        do_read(64'h100, 7, 2, 1, 4'h8, -1, -1);
        repeat (3) @(posedge ACLK);
        #1;
        chk("scoreboard_b_drained", 64'(bq.size()), 64'd0);
        chk("scoreboard_r_drained", 64'(rq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
